// File: rtl/mem_refill_engine_pkg.sv
// Shared constants and FSM state encodings for the cache block refill engine.
package mem_refill_engine_pkg;

  localparam int unsigned WORDS_PER_BLOCK   = 8;
  localparam int unsigned WORD_OFFSET_BITS  = 1;
  localparam int unsigned BLOCK_OFFSET_BITS = 4;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned IDX_W             = 3;
  localparam int unsigned STATE_W           = 3;

  // Refill FSM states
  localparam logic [STATE_W-1:0] ST_QUIET = 3'd0;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd1;
  localparam logic [STATE_W-1:0] ST_ISSUE = 3'd2;
  localparam logic [STATE_W-1:0] ST_DRAIN = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mem_refill_engine_if.sv
// Cache-side and memory-side signals of the refill engine.
interface mem_refill_engine_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              MemoryRequest;
  logic [ADDR_W-1:0] MemoryAddressIn;
  logic [DATA_W-1:0] MemDataIn;
  logic              MemDataValid;
  logic [ADDR_W-1:0] MemAddrOut;
  logic              MemReadEn;
  logic [DATA_W-1:0] RefillData;
  logic [2:0]        RefillWordIdx;
  logic              RefillWrite;
  logic              RefillDone;
  logic              MemStall;

  // Engine side: accepts miss requests, masters main-memory reads
  modport master (
    input  MemoryRequest,
    input  MemoryAddressIn,
    input  MemDataIn,
    input  MemDataValid,
    output MemAddrOut,
    output MemReadEn,
    output RefillData,
    output RefillWordIdx,
    output RefillWrite,
    output RefillDone,
    output MemStall
  );

  // Environment side: cache interface and main memory
  modport slave (
    output MemoryRequest,
    output MemoryAddressIn,
    output MemDataIn,
    output MemDataValid,
    input  MemAddrOut,
    input  MemReadEn,
    input  RefillData,
    input  RefillWordIdx,
    input  RefillWrite,
    input  RefillDone,
    input  MemStall
  );

endinterface

// File: rtl/mem_refill_engine_refill_counter.sv
// Small up-counter with synchronous clear and a terminal-count flag.
module mem_refill_engine_refill_counter #(
  parameter int unsigned W        = 4,
  parameter int unsigned TERMINAL = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         term_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign term_c = (cnt_q == W'(TERMINAL));

endmodule

// File: rtl/mem_refill_engine.sv
// Cache block refill engine: issues one block of pipelined reads on a miss,
// streams the returned words into the data array and signals completion.
module mem_refill_engine #(
  parameter int unsigned WORDS_PER_BLOCK = mem_refill_engine_pkg::WORDS_PER_BLOCK,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_refill_engine_if.master bus
);

  import mem_refill_engine_pkg::*;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  base_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_d;
  logic               read_en_q;
  logic               read_en_d;
  logic               stall_q;
  logic               stall_d;
  logic               done_q;
  logic               done_d;

  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   ret_cnt;
  logic [CNT_W-1:0]   unused_quiet_cnt;
  logic               issue_last;
  logic               ret_last;
  logic               quiet_last;

  logic               in_quiet;
  logic               in_issue;
  logic               in_fetch;
  logic               start;
  logic               ret_accept;
  logic [ADDR_W-1:0]  req_base;
  logic [ADDR_W-1:0]  next_addr;
  logic               unused_addr_lsbs;

  assign in_quiet = (state_q == ST_QUIET);
  assign in_issue = (state_q == ST_ISSUE);
  assign in_fetch = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign start    = (state_q == ST_IDLE) && bus.MemoryRequest;

  // Returns are only taken while a refill is in flight and the block is not full
  assign ret_accept = in_fetch && bus.MemDataValid && (ret_cnt != CNT_W'(WORDS_PER_BLOCK));

  // Block-aligned base of the missing address; the byte offset bits are dropped
  assign req_base  = {bus.MemoryAddressIn[ADDR_W-1:BLOCK_OFFSET_BITS], BLOCK_OFFSET_BITS'(0)};
  assign next_addr = base_q + (ADDR_W'(issue_cnt + CNT_W'(1)) << WORD_OFFSET_BITS);
  assign unused_addr_lsbs = ^bus.MemoryAddressIn[BLOCK_OFFSET_BITS-1:0];

  // Post-reset quiet period: lets stale responses of aborted reads drain away
  mem_refill_engine_refill_counter #(
    .W        (CNT_W),
    .TERMINAL (MEM_LATENCY - 1)
  ) u_quiet_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_quiet),
    .inc    (in_quiet),
    .cnt    (unused_quiet_cnt),
    .term_c (quiet_last)
  );

  // Number of reads issued in the current refill
  mem_refill_engine_refill_counter #(
    .W        (CNT_W),
    .TERMINAL (WORDS_PER_BLOCK - 1)
  ) u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (start),
    .inc    (in_issue),
    .cnt    (issue_cnt),
    .term_c (issue_last)
  );

  // Number of words returned and written in the current refill
  mem_refill_engine_refill_counter #(
    .W        (CNT_W),
    .TERMINAL (WORDS_PER_BLOCK - 1)
  ) u_ret_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (start),
    .inc    (ret_accept),
    .cnt    (ret_cnt),
    .term_c (ret_last)
  );

  // Next-state, base/address and registered-output logic
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;

    case (state_q)
      ST_QUIET: begin
        if (quiet_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.MemoryRequest) begin
          state_d = ST_ISSUE;
          base_d  = req_base;
          addr_d  = req_base;
        end
      end
      ST_ISSUE: begin
        if (!issue_last) begin
          addr_d = next_addr;
        end
        if (ret_accept && ret_last) begin
          state_d = ST_DONE;
        end else if (issue_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ret_accept && ret_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_QUIET;
      end
    endcase

    read_en_d = (state_d == ST_ISSUE);
    stall_d   = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d    = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_QUIET;
      base_q    <= '0;
      addr_q    <= '0;
      read_en_q <= 1'b0;
      stall_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      read_en_q <= read_en_d;
      stall_q   <= stall_d;
      done_q    <= done_d;
    end
  end

  assign bus.MemAddrOut    = addr_q;
  assign bus.MemReadEn     = read_en_q;
  assign bus.MemStall      = stall_q;
  assign bus.RefillDone    = done_q;
  assign bus.RefillWrite   = ret_accept;
  assign bus.RefillWordIdx = ret_accept ? ret_cnt[IDX_W-1:0] : '0;
  assign bus.RefillData    = in_quiet ? DATA_W'(0) : bus.MemDataIn;

endmodule

// File: tb/tb_mem_refill_engine.sv
// Self-checking bench for mem_refill_engine with a latency-accurate memory model.
module tb_mem_refill_engine;

  localparam int LAT = 4;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          due;
  } rd_t;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  rd_t rq[$];
  logic        drv_valid;
  logic [15:0] drv_data;

  always #5 clk = ~clk;

  mem_refill_engine_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_refill_engine #(
    .WORDS_PER_BLOCK (8),
    .ADDR_W          (16),
    .DATA_W          (16),
    .MEM_LATENCY     (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One clock: memory accepts reads seen this cycle and returns due responses
  task automatic tick(input bit allow_ret, input bit force_valid);
    rd_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.MemReadEn === 1'b1) begin
      r.addr = bus.MemAddrOut;
      r.data = 16'($urandom);
      r.due  = cyc + LAT;
      rq.push_back(r);
    end
    drv_valid = 1'b0;
    drv_data  = 16'($urandom);
    if (allow_ret && rq.size() > 0 && rq[0].due <= cyc) begin
      drv_valid = 1'b1;
      drv_data  = rq[0].data;
      void'(rq.pop_front());
    end else if (force_valid) begin
      drv_valid = 1'b1;
    end
    bus.MemDataValid = drv_valid;
    bus.MemDataIn    = drv_data;
    #1;
  endtask

  // Full refill starting in the current (IDLE) cycle; mode 0 no gaps, 1 fixed gaps, 2 random gaps
  task automatic run_refill(input logic [15:0] addr, input int mode, input bit extra_valid,
                            input bit hold_req);
    logic [15:0] base;
    logic [15:0] exp_addr;
    int t, writes, k, c;
    bit done_seen, allow, exp_rd, exp_wr, exp_stall, exp_done;
    base = {addr[15:4], 4'h0};
    bus.MemoryRequest   = 1'b1;
    bus.MemoryAddressIn = addr;
    t = cyc;
    checks++;
    if (bus.MemStall !== 1'b0 || bus.MemReadEn !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_req: stall=%b rden=%b expected 0 0", bus.MemStall, bus.MemReadEn);
    end
    writes = 0;
    done_seen = 1'b0;
    k = 0;
    while (!done_seen && k < 64) begin
      case (mode)
        0:       allow = 1'b1;
        1:       allow = (k % 5 == 0) || (k % 5 == 2) || (k % 5 == 3);
        default: allow = 1'($urandom_range(0, 1));
      endcase
      tick(allow, extra_valid && writes == 8);
      k++;
      c = cyc - t;
      exp_rd    = (c >= 1 && c <= 8);
      exp_stall = (writes < 8);
      exp_done  = (writes == 8);
      exp_wr    = drv_valid && (writes < 8);
      checks++;
      if (bus.MemReadEn !== exp_rd) begin
        errors++;
        $display("FAIL read_en c=%0d: got %b expected %b", c, bus.MemReadEn, exp_rd);
      end
      if (exp_rd) begin
        exp_addr = base + 16'(2 * (c - 1));
        checks++;
        if (bus.MemAddrOut !== exp_addr) begin
          errors++;
          $display("FAIL mem_addr c=%0d: got %h expected %h", c, bus.MemAddrOut, exp_addr);
        end
      end
      checks++;
      if (bus.MemStall !== exp_stall) begin
        errors++;
        $display("FAIL mem_stall c=%0d: got %b expected %b", c, bus.MemStall, exp_stall);
      end
      checks++;
      if (bus.RefillDone !== exp_done) begin
        errors++;
        $display("FAIL refill_done c=%0d: got %b expected %b", c, bus.RefillDone, exp_done);
      end
      checks++;
      if (bus.RefillWrite !== exp_wr) begin
        errors++;
        $display("FAIL refill_write c=%0d: got %b expected %b", c, bus.RefillWrite, exp_wr);
      end
      checks++;
      if (bus.RefillWordIdx !== (exp_wr ? 3'(writes) : 3'd0)) begin
        errors++;
        $display("FAIL word_idx c=%0d: got %0d expected %0d", c, bus.RefillWordIdx,
                 exp_wr ? writes : 0);
      end
      checks++;
      if (bus.RefillData !== drv_data) begin
        errors++;
        $display("FAIL refill_data c=%0d: got %h expected %h", c, bus.RefillData, drv_data);
      end
      if (exp_wr) writes++;
      if (exp_done) begin
        done_seen = 1'b1;
        if (!hold_req) bus.MemoryRequest = 1'b0;
      end
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL refill_timeout: writes=%0d expected 8 and a RefillDone", writes);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.MemoryRequest   = 1'b0;
    bus.MemoryAddressIn = '0;
    bus.MemDataValid    = 1'b0;
    bus.MemDataIn       = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if ({bus.MemAddrOut, bus.MemReadEn, bus.RefillData, bus.RefillWordIdx, bus.RefillWrite,
           bus.RefillDone, bus.MemStall} !== 40'h0) begin
        errors++;
        $display("FAIL reset_outputs: addr=%h rden=%b data=%h idx=%0d wr=%b done=%b stall=%b expected all 0",
                 bus.MemAddrOut, bus.MemReadEn, bus.RefillData, bus.RefillWordIdx,
                 bus.RefillWrite, bus.RefillDone, bus.MemStall);
      end
    end
    bus.MemoryRequest   = 1'b1;
    bus.MemoryAddressIn = 16'h1236;
    rst = 1'b0;
    // Four QUIET cycles: this one plus three more
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(1'b1, 1'b1);
      checks++;
      if ({bus.MemAddrOut, bus.MemReadEn, bus.RefillData, bus.RefillWordIdx, bus.RefillWrite,
           bus.RefillDone, bus.MemStall} !== 40'h0) begin
        errors++;
        $display("FAIL quiet_outputs i=%0d: rden=%b data=%h wr=%b stall=%b expected all 0",
                 i, bus.MemReadEn, bus.RefillData, bus.RefillWrite, bus.MemStall);
      end
    end
  endtask

  task automatic test_basic_refill();
    tick(1'b1, 1'b0);
    checks++;
    if (bus.RefillData !== drv_data) begin
      errors++;
      $display("FAIL first_idle_data: got %h expected %h", bus.RefillData, drv_data);
    end
    run_refill(16'h1236, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    tick(1'b1, 1'b0);
    run_refill(16'($urandom), 1, 1'b0, 1'b0);
    tick(1'b1, 1'b0);
    run_refill(16'($urandom), 2, 1'b0, 1'b0);
  endtask

  task automatic test_extra_valid();
    tick(1'b1, 1'b0);
    run_refill(16'($urandom), 2, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_refill();
    logic [15:0] base;
    logic [15:0] addr;
    tick(1'b1, 1'b0);
    addr = 16'($urandom);
    base = {addr[15:4], 4'h0};
    bus.MemoryRequest   = 1'b1;
    bus.MemoryAddressIn = addr;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (bus.MemReadEn !== 1'b1 || bus.MemAddrOut !== base + 16'(2 * i)) begin
        errors++;
        $display("FAIL abort_issue w=%0d: rden=%b addr=%h expected 1 %h",
                 i, bus.MemReadEn, bus.MemAddrOut, base + 16'(2 * i));
      end
    end
    rst = 1'b1;
    bus.MemoryRequest = 1'b0;
    #1;
    // Reset held two cycles, then released into four QUIET cycles
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick(1'b1, 1'b0);
      if (i == 2) rst = 1'b0;
      checks++;
      if ({bus.MemAddrOut, bus.MemReadEn, bus.RefillData, bus.RefillWordIdx, bus.RefillWrite,
           bus.RefillDone, bus.MemStall} !== 40'h0) begin
        errors++;
        $display("FAIL abort_quiet i=%0d: addr=%h rden=%b data=%h wr=%b stall=%b expected all 0",
                 i, bus.MemAddrOut, bus.MemReadEn, bus.RefillData, bus.RefillWrite, bus.MemStall);
      end
    end
    tick(1'b1, 1'b0);
    checks++;
    if (bus.MemStall !== 1'b0 || bus.RefillWrite !== 1'b0 || bus.RefillData !== drv_data) begin
      errors++;
      $display("FAIL abort_idle: stall=%b wr=%b data=%h expected 0 0 %h",
               bus.MemStall, bus.RefillWrite, bus.RefillData, drv_data);
    end
    run_refill(16'hA000, 0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_request();
    tick(1'b1, 1'b0);
    run_refill(16'($urandom), 0, 1'b0, 1'b1);
    tick(1'b1, 1'b0);
    bus.MemoryRequest = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick(1'b1, 1'($urandom_range(0, 1)));
      checks++;
      if ({bus.MemReadEn, bus.MemStall, bus.RefillDone, bus.RefillWrite} !== 4'b0) begin
        errors++;
        $display("FAIL hold_no_restart i=%0d: rden=%b stall=%b done=%b wr=%b expected 0 0 0 0",
                 i, bus.MemReadEn, bus.MemStall, bus.RefillDone, bus.RefillWrite);
      end
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b0);
    run_refill(16'($urandom), 0, 1'b0, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (bus.MemStall !== 1'b0 || bus.RefillDone !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: stall=%b done=%b expected 0 0", bus.MemStall, bus.RefillDone);
    end
    run_refill(16'hFFF0, 0, 1'b0, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (bus.RefillDone !== 1'b0 || bus.MemStall !== 1'b0 || bus.MemAddrOut !== 16'hFFFE) begin
      errors++;
      $display("FAIL b2b_after: done=%b stall=%b addr=%h expected 0 0 fffe",
               bus.RefillDone, bus.MemStall, bus.MemAddrOut);
    end
  endtask

  initial begin
    test_reset();
    test_basic_refill();
    test_gaps();
    test_extra_valid();
    test_reset_mid_refill();
    test_hold_request();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_refill_engine.md
Name: mem_refill_engine

Overview:
- Memory-side controller downstream of the MEM-stage cache interface.
- On a cache miss it fetches one 8-word (16-byte) block from pipelined main memory, one address per cycle.
- Each returned word is streamed into the cache data array; RefillDone then triggers the tag write.
- It drives the MemStall input of the MEM stage for the whole refill.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block; power of two.
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.
- MEM_LATENCY, 4, main-memory read latency in cycles; also sets the post-reset quiet period.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemoryRequest  in  1  miss request from the cache interface; held high until serviced.
- MemoryAddressIn  in  ADDR_W  miss byte address; only bits [ADDR_W-1:4] are used.
- MemDataIn  in  DATA_W  read data returned by main memory.
- MemDataValid  in  1  MemDataIn valid; responses arrive in issue order.
- MemAddrOut  out  ADDR_W  read address to main memory.
- MemReadEn  out  1  read strobe to main memory; one read per high cycle.
- RefillData  out  DATA_W  word to the cache data array; equals MemDataIn.
- RefillWordIdx  out  3  word index within the block being written.
- RefillWrite  out  1  data-array write enable.
- RefillDone  out  1  one-cycle pulse; block complete, cache writes the tag and valid bit.
- MemStall  out  1  high while a refill is in progress.

Behaviour:
- States: QUIET, IDLE, ISSUE, DRAIN, DONE.
- Reset (async) behaviour:
  - Enter QUIET; zero all counters and the base-address register.
  - All outputs are 0 while rst is high and in QUIET.
- QUIET:
  - Counts MEM_LATENCY cycles, then moves to IDLE.
  - MemDataValid is ignored. This discards responses to reads issued before a mid-refill reset.
- IDLE:
  - If MemoryRequest=1: latch base = {MemoryAddressIn[ADDR_W-1:4],4'b0}, clear IssueCnt and RetCnt, go to ISSUE.
  - MemStall rises in the cycle after the request is sampled.
  - MemDataValid is ignored.
- ISSUE:
  - MemReadEn=1 and MemAddrOut = base + (IssueCnt<<1).
  - IssueCnt increments each cycle; after IssueCnt=7 is issued, go to DRAIN.
  - Exactly 8 reads are issued, at consecutive word addresses base..base+14.
- Returns (ISSUE or DRAIN):
  - When MemDataValid=1 and RetCnt<8: RefillWrite=1, RefillWordIdx=RetCnt, RetCnt increments.
  - Returns may overlap ISSUE; with MEM_LATENCY=4 the first return arrives during issue of word 4.
  - When the 8th return is accepted, go to DONE the next cycle, whatever state the engine is in.
  - MemDataValid with RetCnt=8 is ignored.
- DONE:
  - RefillDone=1 and MemStall=0 for exactly one cycle, then go to IDLE.
  - MemoryRequest is ignored in DONE. The requester drops it in the RefillDone cycle, because the tag write makes the access a hit.
- MemStall is 1 in ISSUE and DRAIN, 0 in QUIET, IDLE and DONE.
- Outputs when not active:
  - MemAddrOut holds its last value when MemReadEn=0; it is 0 after reset.
  - RefillWordIdx=0 and RefillData=MemDataIn whenever RefillWrite=0.
- Widths: IssueCnt and RetCnt are 4 bits, so 8 is representable. Address adds wrap modulo 2^ADDR_W, but never wrap, since the base is 16-byte aligned.
- Overall latency: request sampled at cycle t, then ISSUE t+1..t+8, last return at t+8+MEM_LATENCY, RefillDone one cycle later.

Decomposition:
- Shared package: state enum, WORD_OFFSET_BITS=1, BLOCK_OFFSET_BITS=4, WORDS_PER_BLOCK constant.
- One sub-module, refill_counter: a 4-bit counter with clear, increment and terminal-count flag, instantiated for IssueCnt, RetCnt and the QUIET counter.
- The FSM stays in the top module.

Test Plan:
- Reset, then MemoryRequest=1 with addr 0x1236 at the first IDLE cycle:
  - MemAddrOut = 0x1230, 0x1232, …, 0x123E on 8 consecutive cycles with MemReadEn=1.
  - RefillWordIdx = 0..7 in order.
  - RefillDone pulses once, 1 cycle after the 8th valid; MemStall is high ISSUE through last return.
- Memory model with gaps, where valid returns are stretched with bubbles (valid pattern 1,0,1,1,0,…):
  - RetCnt advances only on valid; 8 writes total; DONE only after the 8th.
  - MemStall stays 1 across the bubbles.
- Extra MemDataValid pulse after 8 returns (same cycle as DONE): RefillWrite stays 0 and there is no 9th write.
- Assert rst during ISSUE at word 3, then release; the memory model keeps returning the 4 in-flight words:
  - All outputs are 0 during reset and QUIET.
  - The stale returns produce no RefillWrite.
  - A new request for 0xA000 refills cleanly with indices 0..7.
- MemoryRequest held high through DONE and then dropped: no second refill starts, and MemStall does not re-rise.
- Back-to-back misses: the requester drops MemoryRequest in the RefillDone cycle, then raises it 1 cycle later with addr 0xFFF0.
  - The second refill issues 0xFFF0..0xFFFE with no address wrap.
  - RefillDone pulses once per refill.
